// File: rtl/sn2bin_dsc.sv
// rtl/sn2bin_dsc.sv - DSC bitstream to binary decoder, optional saturation via SN2BIN_SATURATE_EN
module sn2bin_dsc #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [STRIDE-1:0] sn_in,
    output logic [WIDTH:0]    bin_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              win_done,
    output logic              drop_err
);

    // Counter step and the position of the final sample in a window
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);
    localparam logic [WIDTH-1:0] LAST = WIDTH'((1 << WIDTH) - STRIDE);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] win_cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   pop;
    logic [WIDTH:0]   result;
    logic [WIDTH:0]   load_val;
    logic             close;
    logic             load;
    logic             drop;

    // Number of ones among the STRIDE bits presented this cycle
    always_comb begin
        pop = '0;
        for (int i = 0; i < STRIDE; i++) begin
            pop = pop + (WIDTH + 1)'(sn_in[i]);
        end
    end

    assign close    = en && (win_cnt == LAST);
    assign win_done = close;
    assign result   = acc + pop;

`ifdef SN2BIN_SATURATE_EN
    // A full-scale count is clipped to the generator's top code
    assign load_val = result[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : result;
`else
    assign load_val = result;
`endif

    assign out_valid = (state == FULL);

    // Output register control: load, drop or drain the single entry
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (close) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (close) begin
                    if (out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Window position, accumulator, held result and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            win_cnt  <= '0;
            acc      <= '0;
            bin_out  <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (en) begin
                win_cnt <= win_cnt + STEP;
                acc     <= close ? '0 : result;
            end
            if (load) begin
                bin_out <= load_val;
            end
            if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sn2bin_dsc.sv
// tb/tb_sn2bin_dsc.sv - directed self-checking bench for sn2bin_dsc
module tb_sn2bin_dsc;

`ifdef SN2BIN_SATURATE_EN
    localparam int EXP_FULL = 15;
`else
    localparam int EXP_FULL = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en1 = 1'b0, sn1 = 1'b0, rdy1 = 1'b0;
    logic [4:0] bo1;
    logic       ov1, wd1, de1;

    logic       en2 = 1'b0, rdy2 = 1'b0;
    logic [1:0] sn2 = '0;
    logic [4:0] bo2;
    logic       ov2, wd2, de2;

    logic       en4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] sn4 = '0;
    logic [4:0] bo4;
    logic       ov4, wd4, de4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sn2bin_dsc #(.WIDTH(4), .STRIDE(1)) u_s1 (
        .clk(clk), .rst(rst), .en(en1), .sn_in(sn1), .bin_out(bo1),
        .out_valid(ov1), .out_ready(rdy1), .win_done(wd1), .drop_err(de1)
    );

    sn2bin_dsc #(.WIDTH(4), .STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .en(en2), .sn_in(sn2), .bin_out(bo2),
        .out_valid(ov2), .out_ready(rdy2), .win_done(wd2), .drop_err(de2)
    );

    sn2bin_dsc #(.WIDTH(4), .STRIDE(4)) u_s4 (
        .clk(clk), .rst(rst), .en(en4), .sn_in(sn4), .bin_out(bo4),
        .out_valid(ov4), .out_ready(rdy4), .win_done(wd4), .drop_err(de4)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // One full STRIDE=1 window: generator-style stream with `ones` leading 1s
    task automatic win1(input int ones, input logic rdy_body, input logic rdy_last);
        for (int k = 0; k < 16; k++) begin
            en1  = 1'b1;
            sn1  = (k < ones);
            rdy1 = (k == 15) ? rdy_last : rdy_body;
            #1;
            check("s1_win_done", int'(wd1), int'(k == 15));
            step();
        end
        en1  = 1'b0;
        sn1  = 1'b0;
        rdy1 = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_bin_out", int'(bo1), 0);
        check("rst_out_valid", int'(ov1), 0);
        check("rst_win_done", int'(wd1), 0);
        check("rst_drop_err", int'(de1), 0);
        check("rst_s4_valid", int'(ov4), 0);

        // Generator stream bin_in=9, two back-to-back windows
        win1(9, 1'b1, 1'b1);
        check("t1_valid_a", int'(ov1), 1);
        check("t1_bin_a", int'(bo1), 9);
        win1(9, 1'b1, 1'b1);
        check("t1_valid_b", int'(ov1), 1);
        check("t1_bin_b", int'(bo1), 9);
        check("t1_drop", int'(de1), 0);

        // STRIDE=4: all ones then all zeros
        for (int k = 0; k < 4; k++) begin
            en4 = 1'b1; sn4 = 4'hF; rdy4 = 1'b1;
            #1;
            check("s4_win_done", int'(wd4), int'(k == 3));
            step();
        end
        check("t2_valid", int'(ov4), 1);
        check("t2_bin_full", int'(bo4), EXP_FULL);
        for (int k = 0; k < 4; k++) begin
            sn4 = 4'h0;
            step();
        end
        en4 = 1'b0; rdy4 = 1'b0;
        check("t2_bin_zero", int'(bo4), 0);

        // STRIDE=2 with en toggling; disabled cycles carry junk ones
        for (int i = 0; i < 15; i++) begin
            int c;
            c = i;
            en2 = (i % 2 == 0);
            if (en2) sn2 = {logic'(c + 1 < 5), logic'(c < 5)};
            else     sn2 = 2'b11;
            rdy2 = 1'b1;
            #1;
            check("s2_win_done", int'(wd2), int'(i == 14));
            step();
        end
        en2 = 1'b0; sn2 = '0; rdy2 = 1'b0;
        check("t3_valid", int'(ov2), 1);
        check("t3_bin", int'(bo2), 5);

        // Accept coincident with close: 3 then 7, ready only at second close
        do_reset();
        win1(3, 1'b0, 1'b0);
        check("t5_bin_first", int'(bo1), 3);
        win1(7, 1'b0, 1'b1);
        check("t5_bin_second", int'(bo1), 7);
        check("t5_valid", int'(ov1), 1);
        check("t5_drop", int'(de1), 0);

        // Backpressure across two windows: second result dropped
        do_reset();
        win1(3, 1'b0, 1'b0);
        check("t4_valid_a", int'(ov1), 1);
        check("t4_bin_a", int'(bo1), 3);
        check("t4_drop_a", int'(de1), 0);
        win1(7, 1'b0, 1'b0);
        check("t4_valid_b", int'(ov1), 1);
        check("t4_bin_held", int'(bo1), 3);
        check("t4_drop_b", int'(de1), 1);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        check("t4_drained", int'(ov1), 0);
        check("t4_bin_keep", int'(bo1), 3);
        check("t4_drop_sticky", int'(de1), 1);

        // Mid-window reset after 10 ones
        for (int k = 0; k < 10; k++) begin
            en1 = 1'b1; sn1 = 1'b1;
            step();
        end
        en1 = 1'b0; sn1 = 1'b0;
        do_reset();
        check("t6_bin", int'(bo1), 0);
        check("t6_valid", int'(ov1), 0);
        check("t6_drop", int'(de1), 0);
        check("t6_win_done", int'(wd1), 0);
        win1(16, 1'b0, 1'b0);
        check("t6_bin_full", int'(bo1), EXP_FULL);
        check("t6_valid_full", int'(ov1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sn2bin_dsc.md
# sn2bin_dsc

Stochastic-to-binary decoder for the deterministic stochastic computing (DSC) datapath. It counts the 1s in a unary/DSC bitstream over one full generator period, STRIDE bits per cycle. At each window boundary it presents the count as a binary value on a one-entry ready/valid output. It sits at the output of DSC compute stages (min/max gates, multipliers), paired with the counter-based stream generators that share its WIDTH/STRIDE and reset.

## Interface
- WIDTH, 4: binary precision; one window = 2^WIDTH stream bits; legal 2..16
- STRIDE, 1: stream bits consumed per enabled cycle; legal 1, 2, 4
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample enable; when low, sn_in is ignored and window/accumulator state freezes
- sn_in  in  STRIDE  stream bits; bit 0 is the earliest in stream order
- bin_out  out  WIDTH+1  decoded count of 1s in the last completed window
- out_valid  out  1  bin_out holds an unconsumed result
- out_ready  in  1  consumer accepts bin_out when out_valid && out_ready
- win_done  out  1  one-cycle pulse in the cycle the final sample of a window is taken
- drop_err  out  1  sticky; a completed window result was discarded

## Operation
- Window counter: WIDTH-bit, counts by STRIDE on each cycle with en=1; wraps 2^WIDTH-STRIDE -> 0. Window length is 2^WIDTH/STRIDE enabled cycles. Identical sequence to the generator counter, so both stay aligned from a common rst.
- Accumulator: WIDTH+1 bits. On en=1, acc <= acc + popcount(sn_in). The maximum is 2^WIDTH, so it never overflows.
- Window close is a cycle with en=1 and window counter = 2^WIDTH-STRIDE.
  - win_done=1, combinational on en and the counter.
  - The final result is acc + popcount(sn_in).
  - acc <= 0 and the window counter wraps, so the next enabled sample belongs to the new window.
- Output register (one entry):
  - Load at window close if out_valid=0, or if out_valid && out_ready in the same cycle (accept and reload together; out_valid stays 1).
  - Otherwise the new result is discarded, drop_err <= 1, and the held bin_out is unchanged.
  - out_valid && out_ready with no window close: out_valid <= 0. bin_out keeps its last value.
- drop_err clears only on rst.
- Conceptual FSM on the output register: EMPTY -> FULL on load; FULL -> EMPTY on accept without a coincident load; FULL -> FULL on accept+load or on a drop.

## Timing
- Reset values: bin_out=0, out_valid=0, win_done=0, drop_err=0, acc=0, window counter=0.
- rst asserted mid-window discards the partial count and any held result. The first enabled cycle after rst is window sample 0.
- Latency: if the last sample arrives in cycle t, out_valid=1 and bin_out=result from cycle t+1.
- en=0 in the closing position delays close until the next en=1 cycle. win_done is never asserted with en=0.
- Back-to-back windows with out_ready tied high yield one result every 2^WIDTH/STRIDE enabled cycles with no bubble.
- out_ready is ignored while out_valid=0.

## Configuration
- SN2BIN_SATURATE_EN defined:
  - A result of 2^WIDTH is loaded as 2^WIDTH-1, so bin_out[WIDTH] is always 0.
  - This matches the generator's range of 0..2^WIDTH-1 for round-trip checks.
- SN2BIN_SATURATE_EN undefined: the exact count 0..2^WIDTH is reported.
- The accumulator width is WIDTH+1 in both cases.

## Test plan
- WIDTH=4, STRIDE=1, en=1, out_ready=1, stream from the generator with bin_in=9 (9 ones then 7 zeros):
  - win_done pulses on the 16th cycle.
  - Next cycle: out_valid=1, bin_out=9.
  - Repeats every 16 cycles.
- WIDTH=4, STRIDE=4, sn_in=4'b1111 for 4 cycles:
  - bin_out=16 with the macro undefined.
  - bin_out=15 with SN2BIN_SATURATE_EN defined.
  - A stream of all 0s gives bin_out=0.
- WIDTH=4, STRIDE=2, en toggled 1/0 every cycle, bin_in=5 stream:
  - Window closes after 8 enabled cycles (15 clocks).
  - bin_out=5, with no samples counted on en=0 cycles.
- Backpressure, out_ready=0 for two windows (results 3 then 7):
  - out_valid=1 with bin_out=3 held.
  - drop_err=1 at the second close.
  - Raising out_ready for one cycle drops out_valid to 0.
- Accept coincident with close, out_ready=1 only in the second window's closing cycle:
  - bin_out changes 3->7 with out_valid held at 1.
  - drop_err stays 0.
- rst pulsed after 10 samples of an all-ones window:
  - All outputs go to 0.
  - The next full all-ones window yields bin_out=16, not 26 or 6.
